// File: rtl/cache_assoc_if.sv
// CPU request and memory beat signals of cache_assoc, named from the cache's point of view.
// slave is the cache side; master is the requester/memory side.
interface cache_assoc_if #(
   parameter int unsigned TOTAL_ADDR_W = 18
);
   logic [TOTAL_ADDR_W-1:0] i_ADDR;
   logic [31:0]             i_WDATA;
   logic [3:0]              i_BMASK;
   logic                    i_WREN;
   logic                    i_VALID;
   logic                    o_READY;
   logic [31:0]             o_RDATA;

   logic [TOTAL_ADDR_W-1:0] o_mem_ADDR;
   logic [31:0]             o_mem_WDATA;
   logic [3:0]              o_mem_BMASK;
   logic                    o_mem_WREN;
   logic                    o_mem_VALID;
   logic                    i_mem_READY;
   logic [31:0]             i_mem_RDATA;

   modport slave (
      input  i_ADDR, i_WDATA, i_BMASK, i_WREN, i_VALID, i_mem_READY, i_mem_RDATA,
      output o_READY, o_RDATA, o_mem_ADDR, o_mem_WDATA, o_mem_BMASK, o_mem_WREN, o_mem_VALID
   );

   modport master (
      output i_ADDR, i_WDATA, i_BMASK, i_WREN, i_VALID, i_mem_READY, i_mem_RDATA,
      input  o_READY, o_RDATA, o_mem_ADDR, o_mem_WDATA, o_mem_BMASK, o_mem_WREN, o_mem_VALID
   );
endinterface

// File: rtl/cache_assoc.sv
// Set-associative write-back cache with zero-wait hits and line-sized write-back/fetch bursts.
// Victim is the first invalid way, otherwise a per-set round-robin pointer.
module cache_assoc #(
   parameter int unsigned TOTAL_ADDR_W  = 18,
   parameter int unsigned OFFSET_ADDR_W = 4,
   parameter int unsigned IDX_ADDR_W    = 5,
   parameter int unsigned WAY_W         = 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   cache_assoc_if.slave bus
);
   localparam int unsigned TAG_W = TOTAL_ADDR_W - OFFSET_ADDR_W - IDX_ADDR_W - 2;
   localparam int unsigned WAYS  = 1 << WAY_W;
   localparam int unsigned SETS  = 1 << IDX_ADDR_W;
   localparam int unsigned WORDS = 1 << OFFSET_ADDR_W;
   localparam int unsigned PTR_W = (WAY_W > 0) ? WAY_W : 1;

   typedef enum logic [1:0] {IDLE, WRITE_BACK, FETCH} state_e;

   state_e                   state_q;
   logic [OFFSET_ADDR_W-1:0] cnt_q;
   logic [PTR_W-1:0]         victim_q;
   logic [WAYS-1:0]          valid_q [SETS];
   logic [WAYS-1:0]          dirty_q [SETS];
   logic [TAG_W-1:0]         tag_q   [SETS][WAYS];
   logic [PTR_W-1:0]         ptr_q   [SETS];
   logic [31:0]              data_q  [WAYS][SETS][WORDS];

   logic [OFFSET_ADDR_W-1:0] req_off;
   logic [IDX_ADDR_W-1:0]    req_idx;
   logic [TAG_W-1:0]         req_tag;
   logic                     hit;
   logic [PTR_W-1:0]         hit_way;
   logic                     inv_found;
   logic [PTR_W-1:0]         inv_way;
   logic [PTR_W-1:0]         victim;
   logic [31:0]              rd_word;
   logic [31:0]              wr_word;
   logic                     last_beat;
   logic                     hit_wr;

   assign req_off = bus.i_ADDR[2 +: OFFSET_ADDR_W];
   assign req_idx = bus.i_ADDR[2 + OFFSET_ADDR_W +: IDX_ADDR_W];
   assign req_tag = bus.i_ADDR[TOTAL_ADDR_W-1 -: TAG_W];

   // Tag lookup and victim choice for the current request
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
            hit     = 1'b1;
            hit_way = PTR_W'(w);
         end
         if (!valid_q[req_idx][w] && !inv_found) begin
            inv_found = 1'b1;
            inv_way   = PTR_W'(w);
         end
      end
      victim = inv_found ? inv_way : ptr_q[req_idx];
   end

   assign rd_word   = data_q[hit_way][req_idx][req_off];
   assign last_beat = (cnt_q == {OFFSET_ADDR_W{1'b1}});
   assign hit_wr    = (state_q == IDLE) && bus.i_VALID && hit && bus.i_WREN;

   always_comb begin
      wr_word = rd_word;
      for (int unsigned b = 0; b < 4; b++) begin
         if (bus.i_BMASK[b]) wr_word[8*b +: 8] = bus.i_WDATA[8*b +: 8];
      end
   end

   // Line storage has no reset; only hit writes and fetch beats touch it
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         if (hit_wr) begin
            data_q[hit_way][req_idx][req_off] <= wr_word;
         end else if ((state_q == FETCH) && bus.i_mem_READY) begin
            data_q[victim_q][req_idx][cnt_q] <= bus.i_mem_RDATA;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         victim_q <= '0;
         for (int unsigned s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            ptr_q[s]   <= '0;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               if (hit_wr) begin
                  dirty_q[req_idx][hit_way] <= 1'b1;
               end else if (bus.i_VALID && !hit) begin
                  victim_q <= victim;
                  cnt_q    <= '0;
                  if (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) begin
                     state_q <= WRITE_BACK;
                  end else begin
                     valid_q[req_idx][victim] <= 1'b0;
                     state_q                  <= FETCH;
                  end
               end
            end
            WRITE_BACK: begin
               if (bus.i_mem_READY) begin
                  if (last_beat) begin
                     valid_q[req_idx][victim_q] <= 1'b0;
                     dirty_q[req_idx][victim_q] <= 1'b0;
                     cnt_q                      <= '0;
                     state_q                    <= FETCH;
                  end else begin
                     cnt_q <= cnt_q + OFFSET_ADDR_W'(1);
                  end
               end
            end
            FETCH: begin
               if (bus.i_mem_READY) begin
                  if (last_beat) begin
                     valid_q[req_idx][victim_q] <= 1'b1;
                     dirty_q[req_idx][victim_q] <= 1'b0;
                     tag_q[req_idx][victim_q]   <= req_tag;
                     ptr_q[req_idx]             <= PTR_W'((32'(ptr_q[req_idx]) + 32'd1) % WAYS);
                     cnt_q                      <= '0;
                     state_q                    <= IDLE;
                  end else begin
                     cnt_q <= cnt_q + OFFSET_ADDR_W'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Write-back addresses the victim's old tag, fetch addresses the request tag
   assign bus.o_READY     = (state_q == IDLE) && hit;
   assign bus.o_RDATA     = rd_word;
   assign bus.o_mem_ADDR  = {((state_q == WRITE_BACK) ? tag_q[req_idx][victim_q] : req_tag),
                             req_idx, cnt_q, 2'b00};
   assign bus.o_mem_WDATA = data_q[victim_q][req_idx][cnt_q];
   assign bus.o_mem_BMASK = 4'hF;
   assign bus.o_mem_WREN  = (state_q == WRITE_BACK);
   assign bus.o_mem_VALID = (state_q != IDLE);
endmodule

// File: tb/tb_cache_assoc.sv
// Bench for cache_assoc: directed scenarios plus random traffic against a flat golden memory
// image and a per-set line-allocation model.
module tb_cache_assoc;
   localparam int unsigned AW    = 18;
   localparam int unsigned NWORD = 1 << 16;
   localparam int          SETS  = 32;
   localparam int          WAYS  = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cache_assoc_if #(.TOTAL_ADDR_W(AW)) bus ();

   cache_assoc #(
      .TOTAL_ADDR_W (AW),
      .OFFSET_ADDR_W(4),
      .IDX_ADDR_W   (5),
      .WAY_W        (1)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [17:0] addr;
      logic        wren;
      logic [31:0] wdata;
      int          cyc;
   } beat_t;

   logic [31:0] mem  [NWORD];
   logic [31:0] gold [NWORD];
   beat_t       beat_log[$];
   int          cyc        = 0;
   int          mode       = 0;
   int          hold_after = -1;
   logic        stalled    = 1'b0;
   logic [17:0] st_addr;
   logic [31:0] st_wdata;

   // allocation model: which tag sits in which way, dirty flags, round-robin pointer
   logic       mv [SETS][WAYS];
   logic       md [SETS][WAYS];
   logic [6:0] mt [SETS][WAYS];
   int         mp [SETS];

   always @(posedge clk) cyc++;

   // Memory: decides ready at each falling edge; a beat with valid & ready completes at the next rise
   always @(negedge clk) begin
      logic rdy;
      if (bus.o_mem_VALID === 1'b1 && stalled) begin
         check_eq("stall_addr", 64'(bus.o_mem_ADDR), 64'(st_addr));
         check_eq("stall_wdata", 64'(bus.o_mem_WDATA), 64'(st_wdata));
      end
      case (mode)
         0:       rdy = 1'b1;
         1:       rdy = 1'($urandom_range(0, 1));
         default: rdy = ((cyc % 3) == 0);
      endcase
      if (hold_after >= 0 && beat_log.size() >= hold_after) rdy = 1'b0;
      bus.i_mem_READY = rdy;
      bus.i_mem_RDATA = mem[bus.o_mem_ADDR[17:2]];
      if (bus.o_mem_VALID === 1'b1 && rdy) begin
         check_eq("mem_bmask", 64'(bus.o_mem_BMASK), 64'hF);
         beat_log.push_back('{bus.o_mem_ADDR, bus.o_mem_WREN, bus.o_mem_WDATA, cyc});
         if (bus.o_mem_WREN) mem[bus.o_mem_ADDR[17:2]] = bus.o_mem_WDATA;
      end
      stalled  = (bus.o_mem_VALID === 1'b1) && !rdy;
      st_addr  = bus.o_mem_ADDR;
      st_wdata = bus.o_mem_WDATA;
   end

   task automatic model_reset();
      for (int s = 0; s < SETS; s++) begin
         mp[s] = 0;
         for (int w = 0; w < WAYS; w++) begin
            mv[s][w] = 1'b0;
            md[s][w] = 1'b0;
            mt[s][w] = '0;
         end
      end
      for (int i = 0; i < NWORD; i++) gold[i] = mem[i];
   endtask

   task automatic do_access(input string tag, input logic [17:0] a, input logic wr,
                            input logic [31:0] wd, input logic [3:0] m,
                            output logic [31:0] rd, output int n_wb, output int n_fe);
      int          s;
      logic [6:0]  t;
      bit          hit;
      int          way;
      int          vw;
      int          waited;
      logic [17:0] ba;
      beat_t       expq[$];
      s   = int'(a[10:6]);
      t   = a[17:11];
      hit = 0;
      way = 0;
      rd  = '0;
      for (int i = 0; i < WAYS; i++)
         if (mv[s][i] && mt[s][i] == t) begin hit = 1; way = i; end
      if (!hit) begin
         vw = -1;
         for (int i = 0; i < WAYS; i++) if (!mv[s][i] && vw < 0) vw = i;
         if (vw < 0) vw = mp[s];
         if (mv[s][vw] && md[s][vw])
            for (int k = 0; k < 16; k++) begin
               ba = {mt[s][vw], 5'(s), 4'(k), 2'b00};
               expq.push_back('{ba, 1'b1, gold[ba[17:2]], 0});
            end
         for (int k = 0; k < 16; k++) begin
            ba = {t, 5'(s), 4'(k), 2'b00};
            expq.push_back('{ba, 1'b0, 32'h0, 0});
         end
         mv[s][vw] = 1'b1;
         md[s][vw] = 1'b0;
         mt[s][vw] = t;
         mp[s]     = (mp[s] + 1) % WAYS;
         way       = vw;
      end
      if (wr) md[s][way] = 1'b1;

      beat_log.delete();
      @(negedge clk);
      bus.i_ADDR  = a;
      bus.i_WREN  = wr;
      bus.i_WDATA = wd;
      bus.i_BMASK = m;
      bus.i_VALID = 1'b1;
      #1;
      waited = 0;
      while (bus.o_READY !== 1'b1 && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      check_eq({tag, "_ready"}, 64'(bus.o_READY), 64'd1);
      if (bus.o_READY === 1'b1) begin
         if (hit) check_eq({tag, "_hitwait"}, 64'(waited), 64'd0);
         check_eq({tag, "_nbeats"}, 64'(beat_log.size()), 64'(expq.size()));
         for (int i = 0; i < expq.size() && i < beat_log.size(); i++) begin
            check_eq({tag, "_baddr"}, 64'(beat_log[i].addr), 64'(expq[i].addr));
            check_eq({tag, "_bwren"}, 64'(beat_log[i].wren), 64'(expq[i].wren));
            if (expq[i].wren) check_eq({tag, "_bwdata"}, 64'(beat_log[i].wdata), 64'(expq[i].wdata));
         end
         if (beat_log.size() > 0)
            check_eq({tag, "_lat"}, 64'(cyc), 64'(beat_log[beat_log.size()-1].cyc + 1));
         if (!wr) check_eq({tag, "_rdata"}, 64'(bus.o_RDATA), 64'(gold[a[17:2]]));
         rd = bus.o_RDATA;
      end
      n_wb = 0;
      n_fe = 0;
      foreach (beat_log[i]) if (beat_log[i].wren) n_wb++; else n_fe++;
      @(posedge clk);
      #1;
      bus.i_VALID = 1'b0;
      if (wr)
         for (int b = 0; b < 4; b++)
            if (m[b]) gold[a[17:2]][8*b +: 8] = wd[8*b +: 8];
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] orig;
      int          nw;
      int          nf;
      int          waited;
      logic [17:0] ra;

      for (int i = 0; i < NWORD; i++) mem[i] = $urandom;
      rst         = 1'b1;
      bus.i_VALID = 1'b0;
      bus.i_ADDR  = '0;
      bus.i_WDATA = '0;
      bus.i_BMASK = '0;
      bus.i_WREN  = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("rst_ready", 64'(bus.o_READY), 64'd0);
      check_eq("rst_mem_valid", 64'(bus.o_mem_VALID), 64'd0);
      check_eq("rst_mem_wren", 64'(bus.o_mem_WREN), 64'd0);

      // idle with no request: no memory traffic
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.i_ADDR = 18'($urandom) & 18'h3FFFC;
         #1;
         check_eq("idle_mem_valid", 64'(bus.o_mem_VALID), 64'd0);
      end

      do_access("cold", 18'h00040, 1'b0, 32'h0, 4'h0, rd, nw, nf);
      check_eq("cold_fetch", 64'(nf), 64'd16);
      check_eq("cold_wb", 64'(nw), 64'd0);

      orig = mem[18'h00044 >> 2];
      do_access("wrhit", 18'h00044, 1'b1, 32'hDEADBEEF, 4'b0011, rd, nw, nf);
      check_eq("wrhit_beats", 64'(nw + nf), 64'd0);
      do_access("wrback", 18'h00044, 1'b0, 32'h0, 4'h0, rd, nw, nf);
      check_eq("wrback_data", 64'(rd), 64'({orig[31:16], 16'hBEEF}));

      do_access("s0_t1", 18'h00800, 1'b0, 32'h0, 4'h0, rd, nw, nf);
      do_access("s0_t1w", 18'h00808, 1'b1, 32'h12345678, 4'hF, rd, nw, nf);
      do_access("s0_t2", 18'h01000, 1'b0, 32'h0, 4'h0, rd, nw, nf);
      do_access("s0_t3", 18'h01800, 1'b0, 32'h0, 4'h0, rd, nw, nf);
      check_eq("evict_wb", 64'(nw), 64'd16);
      check_eq("evict_fetch", 64'(nf), 64'd16);
      do_access("s0_t2hit", 18'h01004, 1'b0, 32'h0, 4'h0, rd, nw, nf);
      check_eq("t2_still_hit", 64'(nw + nf), 64'd0);
      check_eq("t1_in_mem", 64'(mem[18'h00808 >> 2]), 64'h12345678);

      do_access("clean_conf", 18'h02000, 1'b0, 32'h0, 4'h0, rd, nw, nf);
      check_eq("clean_wb", 64'(nw), 64'd0);
      check_eq("clean_fetch", 64'(nf), 64'd16);

      mode = 2;
      do_access("slow", 18'h04100, 1'b0, 32'h0, 4'h0, rd, nw, nf);
      check_eq("slow_fetch", 64'(nf), 64'd16);
      for (int k = 0; k < 16; k += 5)
         do_access("slow_word", 18'h04100 + 18'(4 * k), 1'b0, 32'h0, 4'h0, rd, nw, nf);
      mode = 0;

      // reset in the middle of a fetch burst
      hold_after = 7;
      beat_log.delete();
      @(negedge clk);
      bus.i_ADDR  = 18'h03080;
      bus.i_WREN  = 1'b0;
      bus.i_VALID = 1'b1;
      waited = 0;
      while (beat_log.size() < 7 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check_eq("abort_beats", 64'(beat_log.size()), 64'd7);
      repeat (2) @(negedge clk);
      rst         = 1'b1;
      bus.i_VALID = 1'b0;
      @(negedge clk);
      #1;
      check_eq("abort_mem_valid", 64'(bus.o_mem_VALID), 64'd0);
      check_eq("abort_ready", 64'(bus.o_READY), 64'd0);
      rst        = 1'b0;
      hold_after = -1;
      model_reset();
      do_access("refetch", 18'h03080, 1'b0, 32'h0, 4'h0, rd, nw, nf);
      check_eq("refetch_beats", 64'(nf), 64'd16);

      // random traffic on a few sets and tags to force hits, clean and dirty evictions
      mode = 1;
      for (int n = 0; n < 200; n++) begin
         ra = {7'($urandom_range(0, 5)), 5'($urandom_range(0, 3)), 4'($urandom), 2'b00};
         do_access("rnd", ra, 1'($urandom), $urandom, 4'($urandom), rd, nw, nf);
      end
      mode = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
